// File: rtl/apb_requester.sv
// Single-outstanding APB initiator. Turns a valid/ready command stream into
// APB SETUP/ACCESS phases and returns read data and error status on a
// valid/ready response stream. A wait-state watchdog aborts transfers to a
// completer that never raises pready.
module apb_requester #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    // command stream
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    // response stream
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [DATA_WIDTH-1:0] o_resp_rdata,
    output logic                  o_resp_err,
    output logic                  o_resp_timeout,
    output logic                  o_busy,
    // APB initiator side
    output logic                  o_psel,
    output logic                  o_penable,
    output logic                  o_pwrite,
    output logic [ADDR_WIDTH-1:0] o_paddr,
    output logic [DATA_WIDTH-1:0] o_pwdata,
    input  logic                  i_pready,
    input  logic [DATA_WIDTH-1:0] i_prdata,
    input  logic                  i_pslverr
);

    if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
        $error("apb_requester: DATA_WIDTH must be a multiple of 8");
    end

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // A disabled watchdog still keeps a 1-bit counter so the logic stays uniform.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_resp_err;
    logic                  r_resp_timeout;
    logic                  r_busy;

    logic                  w_cmd_ready;
    logic                  w_cnt_sat;
    logic                  w_timeout_hit;

    // Command acceptance is only possible in IDLE; watchdog decode from the counter.
    always_comb begin
        w_cmd_ready   = (r_state == S_IDLE);
        w_cnt_sat     = &r_wait_cnt;
        w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_wait_cnt == CNT_LAST);
    end

    // Transfer sequencer: all bus and response outputs are registered here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_wait_cnt     <= '0;
            r_psel         <= 1'b0;
            r_penable      <= 1'b0;
            r_pwrite       <= 1'b0;
            r_paddr        <= '0;
            r_pwdata       <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_rdata   <= '0;
            r_resp_err     <= 1'b0;
            r_resp_timeout <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_paddr   <= i_cmd_addr;
                        r_pwdata  <= i_cmd_wdata;
                        r_pwrite  <= i_cmd_write;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable  <= 1'b1;
                    r_wait_cnt <= '0;
                    r_state    <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (i_pready) begin
                        r_resp_rdata   <= r_pwrite ? '0 : i_prdata;
                        r_resp_err     <= i_pslverr;
                        r_resp_timeout <= 1'b0;
                        r_psel         <= 1'b0;
                        r_penable      <= 1'b0;
                        r_resp_valid   <= 1'b1;
                        r_state        <= S_RESP;
                    end else if (w_timeout_hit) begin
                        r_resp_rdata   <= '0;
                        r_resp_err     <= 1'b1;
                        r_resp_timeout <= 1'b1;
                        r_psel         <= 1'b0;
                        r_penable      <= 1'b0;
                        r_resp_valid   <= 1'b1;
                        r_state        <= S_RESP;
                    end else if (!w_cnt_sat) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (i_resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output mapping.
    always_comb begin
        o_cmd_ready    = w_cmd_ready;
        o_resp_valid   = r_resp_valid;
        o_resp_rdata   = r_resp_rdata;
        o_resp_err     = r_resp_err;
        o_resp_timeout = r_resp_timeout;
        o_busy         = r_busy;
        o_psel         = r_psel;
        o_penable      = r_penable;
        o_pwrite       = r_pwrite;
        o_paddr        = r_paddr;
        o_pwdata       = r_pwdata;
    end

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: directed table, hand-written corner
// sequences, and randomized transfers against a transaction-level model.
module tb_apb_requester;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 4;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic          i_rst;
    logic          i_cmd_valid, i_cmd_write, i_resp_ready, i_pready, i_pslverr;
    logic [AW-1:0] i_cmd_addr;
    logic [DW-1:0] i_cmd_wdata, i_prdata;
    logic          o_cmd_ready, o_resp_valid, o_resp_err, o_resp_timeout, o_busy;
    logic          o_psel, o_penable, o_pwrite;
    logic [AW-1:0] o_paddr;
    logic [DW-1:0] o_pwdata, o_resp_rdata;

    // Second instance with the watchdog disabled.
    logic          c2_cmd_valid, c2_cmd_write, c2_resp_ready, c2_pready, c2_pslverr;
    logic [AW-1:0] c2_cmd_addr;
    logic [DW-1:0] c2_cmd_wdata, c2_prdata;
    logic          d2_cmd_ready, d2_resp_valid, d2_resp_err, d2_resp_timeout, d2_busy;
    logic          d2_psel, d2_penable, d2_pwrite;
    logic [AW-1:0] d2_paddr;
    logic [DW-1:0] d2_pwdata, d2_resp_rdata;

    apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
        .o_resp_timeout(o_resp_timeout), .o_busy(o_busy),
        .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
        .o_paddr(o_paddr), .o_pwdata(o_pwdata),
        .i_pready(i_pready), .i_prdata(i_prdata), .i_pslverr(i_pslverr)
    );

    apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) u_dut_nowd (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_valid(c2_cmd_valid), .o_cmd_ready(d2_cmd_ready), .i_cmd_write(c2_cmd_write),
        .i_cmd_addr(c2_cmd_addr), .i_cmd_wdata(c2_cmd_wdata),
        .o_resp_valid(d2_resp_valid), .i_resp_ready(c2_resp_ready),
        .o_resp_rdata(d2_resp_rdata), .o_resp_err(d2_resp_err),
        .o_resp_timeout(d2_resp_timeout), .o_busy(d2_busy),
        .o_psel(d2_psel), .o_penable(d2_penable), .o_pwrite(d2_pwrite),
        .o_paddr(d2_paddr), .o_pwdata(d2_pwdata),
        .i_pready(c2_pready), .i_prdata(c2_prdata), .i_pslverr(c2_pslverr)
    );

    int n_checks = 0;
    int n_errs   = 0;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] prd;
        bit          slverr;
        int          waits;
        bit          err_in_wait;
        int          resp_delay;
        logic [15:0] e_rdata;
        bit          e_err;
        bit          e_to;
        int          e_lat;
        int          e_psel;
    } vec_t;

    typedef struct {
        logic [15:0] rdata;
        bit          err;
        bit          to;
        int          access_cycles;
    } exp_t;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: outcome of one transfer given how long the
    // completer stalls.
    function automatic exp_t model(bit wr, int waits, logic [15:0] prd, bit slverr);
        exp_t e;
        if (TO != 0 && waits >= int'(TO)) begin
            e.rdata = 16'h0; e.err = 1'b1; e.to = 1'b1; e.access_cycles = TO;
        end else begin
            e.rdata = wr ? 16'h0 : prd; e.err = slverr; e.to = 1'b0;
            e.access_cycles = waits + 1;
        end
        return e;
    endfunction

    function automatic vec_t mk(bit wr, logic [15:0] addr, logic [15:0] wdata, logic [15:0] prd,
                                bit slverr, int waits, bit eiw, int rdly, logic [15:0] er,
                                bit ee, bit eto, int elat, int epsel);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.prd = prd; v.slverr = slverr;
        v.waits = waits; v.err_in_wait = eiw; v.resp_delay = rdly;
        v.e_rdata = er; v.e_err = ee; v.e_to = eto; v.e_lat = elat; v.e_psel = epsel;
        return v;
    endfunction

    // Drive one transfer from IDLE and check the bus phases and the response.
    task automatic run_txn(input string tag, input vec_t v);
        int cyc;
        int psel_cnt;
        int acc;
        bit got;
        bit unstable;
        bit hold_bad;
        i_cmd_valid = 1'b1; i_cmd_write = v.wr; i_cmd_addr = v.addr; i_cmd_wdata = v.wdata;
        i_resp_ready = 1'b0;
        chk({tag, " cmd_ready"}, o_cmd_ready, 1);
        tick();
        i_cmd_valid = 1'b0; i_cmd_addr = ~v.addr; i_cmd_wdata = ~v.wdata; i_cmd_write = ~v.wr;
        chk({tag, " setup psel"}, o_psel, 1);
        chk({tag, " setup penable"}, o_penable, 0);
        chk({tag, " setup paddr"}, o_paddr, v.addr);
        chk({tag, " setup pwrite"}, o_pwrite, v.wr);
        chk({tag, " busy"}, o_busy, 1);
        psel_cnt = o_psel ? 1 : 0;
        tick();
        cyc = 2; acc = 0; got = 0; unstable = 0;
        while (cyc < 40) begin
            if (o_resp_valid) begin
                got = 1;
                break;
            end
            if (o_psel) psel_cnt++;
            if (o_psel !== 1'b1 || o_penable !== 1'b1 || o_paddr !== v.addr ||
                o_pwdata !== v.wdata || o_pwrite !== v.wr) unstable = 1;
            i_pready = (acc >= v.waits);
            i_prdata = i_pready ? v.prd : 16'($urandom);
            i_pslverr = i_pready ? v.slverr : v.err_in_wait;
            tick();
            i_pready = 1'b0; i_pslverr = 1'b0;
            cyc++; acc++;
        end
        chk({tag, " resp seen"}, got, 1);
        chk({tag, " latency"}, cyc, v.e_lat);
        chk({tag, " psel cycles"}, psel_cnt, v.e_psel);
        chk({tag, " bus stable"}, unstable, 0);
        chk({tag, " psel drop"}, {o_psel, o_penable}, 0);
        chk({tag, " rdata"}, o_resp_rdata, v.e_rdata);
        chk({tag, " err"}, o_resp_err, v.e_err);
        chk({tag, " timeout"}, o_resp_timeout, v.e_to);
        hold_bad = 0;
        for (int k = 0; k < v.resp_delay; k++) begin
            tick();
            if (o_resp_valid !== 1'b1 || o_resp_rdata !== v.e_rdata || o_resp_err !== v.e_err ||
                o_resp_timeout !== v.e_to || o_cmd_ready !== 1'b0) hold_bad = 1;
        end
        chk({tag, " resp hold"}, hold_bad, 0);
        i_resp_ready = 1'b1;
        tick();
        i_resp_ready = 1'b0;
        chk({tag, " resp cleared"}, o_resp_valid, 0);
        chk({tag, " idle"}, {o_cmd_ready, o_busy}, 2'b10);
    endtask

    vec_t vecs[7];

    initial begin
        bit   flag;
        vec_t v;
        exp_t e;

        i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0;
        i_cmd_wdata = '0; i_resp_ready = 1'b0; i_pready = 1'b0; i_prdata = '0;
        i_pslverr = 1'b0;
        c2_cmd_valid = 1'b0; c2_cmd_write = 1'b0; c2_cmd_addr = '0; c2_cmd_wdata = '0;
        c2_resp_ready = 1'b0; c2_pready = 1'b0; c2_prdata = '0; c2_pslverr = 1'b0;

        //          wr addr      wdata     prd       se wt ew dly  rdata    ee to lat psel
        vecs[0] = mk(0, 16'h0010, 16'h0000, 16'hBEEF, 0, 0, 0, 0, 16'hBEEF, 0, 0, 3, 2);
        vecs[1] = mk(1, 16'h0004, 16'h1234, 16'hAAAA, 0, 3, 0, 1, 16'h0000, 0, 0, 6, 5);
        vecs[2] = mk(0, 16'h0020, 16'h5555, 16'hDEAD, 1, 0, 0, 2, 16'hDEAD, 1, 0, 3, 2);
        vecs[3] = mk(0, 16'h0030, 16'h0001, 16'h5A5A, 0, 2, 1, 0, 16'h5A5A, 0, 0, 5, 4);
        vecs[4] = mk(0, 16'h0040, 16'h0002, 16'h7777, 0, 10, 0, 3, 16'h0000, 1, 1, 6, 5);
        vecs[5] = mk(1, 16'h0050, 16'hCAFE, 16'h3333, 1, 3, 0, 0, 16'h0000, 1, 0, 6, 5);
        vecs[6] = mk(1, 16'h0060, 16'hF00D, 16'h4444, 0, 4, 1, 1, 16'h0000, 1, 1, 6, 5);

        tick(); tick();
        i_rst = 1'b0;
        chk("reset psel/penable/pwrite", {o_psel, o_penable, o_pwrite}, 0);
        chk("reset resp flags", {o_resp_valid, o_resp_err, o_resp_timeout}, 0);
        chk("reset busy", o_busy, 0);
        chk("reset paddr", o_paddr, 0);
        chk("reset pwdata", o_pwdata, 0);
        chk("reset resp_rdata", o_resp_rdata, 0);
        chk("reset cmd_ready", o_cmd_ready, 1);

        for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        // Backpressure with a second command waiting.
        i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 16'h0068;
        tick();
        i_cmd_valid = 1'b0;
        tick();
        i_pready = 1'b1; i_prdata = 16'h1111; i_pslverr = 1'b0;
        tick();
        i_pready = 1'b0;
        chk("bp first resp", {o_resp_valid, 16'(o_resp_rdata)}, {1'b1, 16'h1111});
        i_cmd_valid = 1'b1; i_cmd_write = 1'b1; i_cmd_addr = 16'h0070; i_cmd_wdata = 16'h2222;
        flag = 0;
        for (int k = 0; k < 5; k++) begin
            if (o_cmd_ready !== 1'b0 || o_resp_valid !== 1'b1 || o_resp_rdata !== 16'h1111 ||
                o_resp_err !== 1'b0 || o_psel !== 1'b0) flag = 1;
            tick();
        end
        chk("bp hold", flag, 0);
        i_resp_ready = 1'b1;
        tick();
        i_resp_ready = 1'b0;
        chk("bp resp done", o_resp_valid, 0);
        chk("bp accept ready", o_cmd_ready, 1);
        tick();
        i_cmd_valid = 1'b0;
        chk("bp second setup", {o_psel, o_penable, o_pwrite}, 3'b101);
        chk("bp second paddr", o_paddr, 16'h0070);
        chk("bp second pwdata", o_pwdata, 16'h2222);
        tick();
        chk("bp second access", o_penable, 1);
        i_pready = 1'b1; i_prdata = 16'h9876;
        tick();
        i_pready = 1'b0;
        chk("bp second resp", {o_resp_valid, o_resp_err, 16'(o_resp_rdata)}, 18'h20000);
        i_resp_ready = 1'b1;
        tick();
        i_resp_ready = 1'b0;

        // Reset in ACCESS together with pready.
        i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_addr = 16'h0080;
        tick();
        i_cmd_valid = 1'b0;
        tick();
        i_pready = 1'b1; i_prdata = 16'h9999; i_rst = 1'b1;
        tick();
        i_rst = 1'b0; i_pready = 1'b0;
        chk("rst psel/penable", {o_psel, o_penable}, 0);
        chk("rst resp_valid/busy", {o_resp_valid, o_busy}, 0);
        chk("rst cmd_ready", o_cmd_ready, 1);
        flag = 0;
        for (int k = 0; k < 5; k++) begin
            if (o_resp_valid !== 1'b0) flag = 1;
            tick();
        end
        chk("rst no response", flag, 0);
        run_txn("after rst", mk(0, 16'h0090, 16'h0, 16'h0BAD, 0, 1, 0, 0, 16'h0BAD, 0, 0, 4, 3));

        // Randomized transfers against the model.
        for (int i = 0; i < 40; i++) begin
            v.wr = 1'($urandom_range(0, 1));
            v.addr = 16'($urandom); v.wdata = 16'($urandom); v.prd = 16'($urandom);
            v.slverr = 1'($urandom_range(0, 1)); v.waits = $urandom_range(0, 6);
            v.err_in_wait = 1'($urandom_range(0, 1)); v.resp_delay = $urandom_range(0, 3);
            e = model(v.wr, v.waits, v.prd, v.slverr);
            v.e_rdata = e.rdata; v.e_err = e.err; v.e_to = e.to;
            v.e_lat = 2 + e.access_cycles; v.e_psel = 1 + e.access_cycles;
            run_txn($sformatf("rnd%0d", i), v);
        end

        // Watchdog disabled: a long stall never aborts.
        c2_cmd_valid = 1'b1; c2_cmd_write = 1'b0; c2_cmd_addr = 16'h0100;
        tick();
        c2_cmd_valid = 1'b0;
        chk("nowd setup psel", d2_psel, 1);
        tick();
        flag = 0;
        for (int k = 0; k < 1000; k++) begin
            if (d2_psel !== 1'b1 || d2_penable !== 1'b1 || d2_resp_valid !== 1'b0) flag = 1;
            tick();
        end
        chk("nowd no abort", flag, 0);
        chk("nowd busy", d2_busy, 1);
        c2_pready = 1'b1; c2_prdata = 16'h4321;
        tick();
        c2_pready = 1'b0;
        chk("nowd resp", {d2_resp_valid, d2_resp_err, d2_resp_timeout}, 3'b100);
        chk("nowd rdata", d2_resp_rdata, 16'h4321);
        c2_resp_ready = 1'b1;
        tick();
        c2_resp_ready = 1'b0;
        chk("nowd done", {d2_resp_valid, d2_cmd_ready}, 2'b01);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global time limit: got running, expected finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- Single-outstanding APB initiator. Converts a valid/ready command stream (address, write data, direction) into APB SETUP and ACCESS phases.
- Returns the read data and error status on a valid/ready response stream.
- Drives the completer side of management-bus peripherals such as status and control registers.
- Includes a wait-state watchdog so that a hung completer cannot stall the initiating logic.

Parameters:
- ADDR_WIDTH, 16: width of paddr and cmd_addr.
- DATA_WIDTH, 16: width of pwdata, prdata, cmd_wdata and resp_rdata.
- TIMEOUT_CYCLES, 255: maximum number of ACCESS cycles with pready low before the transfer is aborted. A value of 0 disables the watchdog.

Ports:
- clk  input  1  Bus clock. All logic is on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- cmd_valid  input  1  Command present.
- cmd_ready  output  1  Command accepted when high together with cmd_valid.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WIDTH  Target address.
- cmd_wdata  input  DATA_WIDTH  Write data; ignored for reads.
- resp_valid  output  1  Response present.
- resp_ready  input  1  Response consumed when high together with resp_valid.
- resp_rdata  output  DATA_WIDTH  Captured prdata; 0 for writes and on timeout.
- resp_err  output  1  Completer signalled pslverr, or the transfer timed out.
- resp_timeout  output  1  Transfer was aborted by the watchdog.
- busy  output  1  High in every state except IDLE.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  ADDR_WIDTH  APB address.
- pwdata  output  DATA_WIDTH  APB write data.
- pready  input  1  Completer ready.
- prdata  input  DATA_WIDTH  Completer read data.
- pslverr  input  1  Completer error.

Behaviour:
- Reset values: state IDLE; psel, penable, pwrite, resp_valid, resp_err, resp_timeout and busy all 0; paddr, pwdata and resp_rdata all 0; wait counter 0.
- State machine states are IDLE, SETUP, ACCESS and RESP. Every output except cmd_ready is registered.
- cmd_ready = (state == IDLE), combinational.
- IDLE:
  - On cmd_valid && cmd_ready, latch cmd_addr into paddr, cmd_wdata into pwdata and cmd_write into pwrite.
  - Set psel=1 and penable=0, then go to SETUP.
- SETUP:
  - Lasts exactly one cycle.
  - Set penable=1 and clear the wait counter, then go to ACCESS.
- ACCESS with pready=1:
  - Capture resp_rdata = pwrite ? 0 : prdata.
  - Set resp_err = pslverr and resp_timeout = 0.
  - Clear psel and penable, set resp_valid=1, go to RESP.
- ACCESS with pready=0:
  - Increment the wait counter.
  - If TIMEOUT_CYCLES != 0 and the counter equals TIMEOUT_CYCLES-1, abort instead: clear psel and penable, set resp_rdata=0, resp_err=1, resp_timeout=1 and resp_valid=1, then go to RESP. The abort falls on the TIMEOUT_CYCLES-th consecutive low-pready ACCESS cycle.
- Wait counter:
  - Width is $clog2(TIMEOUT_CYCLES+1), minimum 1 bit.
  - It saturates and never wraps.
- RESP:
  - Hold resp_* stable while resp_valid && !resp_ready.
  - On resp_ready, clear resp_valid and go to IDLE.
  - A new command can be accepted on the cycle after the response handshake.
- paddr, pwdata and pwrite remain stable from SETUP through the final ACCESS cycle. They retain their last value when idle.
- pready, prdata and pslverr are ignored outside ACCESS. pslverr is sampled only when pready is high.
- Minimum latency: command accepted in cycle N, SETUP in N+1, ACCESS in N+2 (pready high), resp_valid high in N+3. Each wait state adds one cycle.
- cmd_valid while busy is not accepted. The command stays pending, per the valid/ready rules, until IDLE.
- Reset mid-transfer: on the next edge psel, penable and resp_valid go to 0 and the state returns to IDLE. The in-flight response is discarded and no response is issued for it.
- Reset has priority over every other event, including a simultaneous pready or resp_ready.
- DATA_WIDTH must be a multiple of 8. Any other value causes an elaboration error.

Test Plan:
- Zero-wait read: cmd addr=0x0010, read, with completer pready=1 and prdata=0xBEEF in the first ACCESS cycle -> psel rises at N+1 and penable at N+2; resp_valid at N+3 with rdata=0xBEEF, err=0, timeout=0.
- Write with 3 wait states: addr=0x0004, wdata=0x1234, pready low for 3 ACCESS cycles -> paddr and pwdata stable for 5 psel cycles; resp_rdata=0x0000, err=0; resp_valid at N+6.
- Slave error: read with pslverr=1 and pready=1 -> resp_err=1, resp_timeout=0, rdata=prdata. Repeat with pslverr=1 and pready=0 to confirm pslverr is ignored until pready is high.
- Timeout: TIMEOUT_CYCLES=4, pready held 0 -> psel drops after exactly 4 ACCESS cycles; resp err=1, timeout=1, rdata=0. Repeat with TIMEOUT_CYCLES=0 and pready held low for 1000 cycles -> no abort.
- Backpressure and overlap: hold resp_ready=0 for 5 cycles while cmd_valid is asserted with a second command -> response stable; cmd_ready=0 throughout. The second command is accepted the cycle after resp_ready=1, and its SETUP follows.
- Reset in ACCESS, asserted at the same time as pready=1 -> the next cycle has psel=0, penable=0, resp_valid=0, busy=0; no response is ever produced. A following read completes normally.
